// File: rtl/evu_pkg.sv
// Shared types and constants for the EVU event counter slice.
// Optional feature macro: EVU_CNT_SATURATE_EN (saturating counters instead of wrap).
package evu_pkg;

  localparam int unsigned EVU_NUM_LINES = 4;

  typedef enum logic [1:0] {
    EVU_PRIV_INV = 2'b00,
    EVU_PRIV_M   = 2'b01,
    EVU_PRIV_S   = 2'b10,
    EVU_PRIV_U   = 2'b11
  } evu_priv_e;

  typedef enum logic [1:0] {
    DUMP_IDLE  = 2'd0,
    DUMP_SNAP  = 2'd1,
    DUMP_DRAIN = 2'd2
  } evu_dump_state_e;

  // mask bit0=M, bit1=S, bit2=U; the invalid encoding never counts
  function automatic logic evu_priv_allowed(logic [1:0] priv, logic [2:0] mask);
    logic ok;
    ok = 1'b0;
    case (evu_priv_e'(priv))
      EVU_PRIV_M: ok = mask[0];
      EVU_PRIV_S: ok = mask[1];
      EVU_PRIV_U: ok = mask[2];
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/evu_event_counter_if.sv
// Snapshot stream port of the EVU event counter (valid/ready toward SPU/trace).
interface evu_event_counter_if #(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned IDX_W     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
);
  logic                 dump_valid_o;
  logic                 dump_ready_i;
  logic [IDX_W-1:0]     dump_idx_o;
  logic [CNT_WIDTH-1:0] dump_data_o;
  logic                 dump_last_o;

  modport master (
    output dump_valid_o,
    input  dump_ready_i,
    output dump_idx_o,
    output dump_data_o,
    output dump_last_o
  );

  modport slave (
    input  dump_valid_o,
    output dump_ready_i,
    input  dump_idx_o,
    input  dump_data_o,
    input  dump_last_o
  );
endinterface

// File: rtl/evu_line_counter.sv
// One event line: counter with clear, snapshot-clear, sticky threshold and overflow flags.
// EVU_CNT_SATURATE_EN selects hold-at-all-ones instead of wrap-around.
module evu_line_counter
  import evu_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_i,
  input  logic                 clear_i,
  input  logic                 snap_i,
  input  logic [CNT_WIDTH-1:0] threshold_i,
  output logic [CNT_WIDTH-1:0] snap_val_o,
  output logic                 irq_o,
  output logic                 ovf_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 inc;
  logic                 at_max;
  logic                 hit;

  // next counter value, including this cycle's increment (clear drops it)
  always_comb begin
    inc    = inc_i & ~clear_i;
    at_max = &cnt_q;
`ifdef EVU_CNT_SATURATE_EN
    cnt_inc = at_max ? cnt_q : cnt_q + CNT_WIDTH'(1);
`else
    cnt_inc = cnt_q + CNT_WIDTH'(1);
`endif
    cnt_next   = inc ? cnt_inc : cnt_q;
    snap_val_o = cnt_next;
    // threshold fires only on an actual transition onto the threshold value
    hit = inc && (cnt_next != cnt_q) && (threshold_i != '0) && (cnt_next == threshold_i);
  end

  // counter and sticky flags; clear beats snapshot-clear beats increment
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      irq_o <= 1'b0;
      ovf_o <= 1'b0;
    end else if (clear_i) begin
      cnt_q <= '0;
      irq_o <= 1'b0;
      ovf_o <= 1'b0;
    end else begin
      cnt_q <= snap_i ? '0 : cnt_next;
      if (inc && at_max) ovf_o <= 1'b1;
      if (hit)           irq_o <= 1'b1;
    end
  end

endmodule

// File: rtl/evu_event_counter.sv
// EVU event bus consumer: filters event pulses by privilege/ASID, counts per line,
// and streams an atomic snapshot of all counters on request.
// EVU_CNT_SATURATE_EN selects saturating counters (see evu_line_counter).
module evu_event_counter
  import evu_pkg::*;
#(
  parameter int unsigned NUM_LINES  = EVU_NUM_LINES,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned ASID_WIDTH = 16,
  parameter int unsigned IDX_W      = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_LINES-1:0]  evt_id_i,
  input  logic [1:0]            evt_priv_i,
  input  logic [ASID_WIDTH-1:0] evt_asid_i,
  input  logic [NUM_LINES-1:0]  cfg_line_en_i,
  input  logic [2:0]            cfg_priv_mask_i,
  input  logic                  cfg_asid_en_i,
  input  logic [ASID_WIDTH-1:0] cfg_asid_i,
  input  logic [CNT_WIDTH-1:0]  cfg_threshold_i,
  input  logic                  clear_i,
  input  logic                  dump_req_i,
  output logic                  dump_busy_o,
  evu_event_counter_if.master   dump,
  output logic [NUM_LINES-1:0]  irq_o,
  output logic [NUM_LINES-1:0]  ovf_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  evu_dump_state_e      state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [CNT_WIDTH-1:0] shadow_q [NUM_LINES];
  logic [CNT_WIDTH-1:0] snap_val [NUM_LINES];
  logic [NUM_LINES-1:0] inc;
  logic                 qual;
  logic                 snap;

  // shared event qualification (privilege and ASID), then per-line gating
  always_comb begin
    qual = evu_priv_allowed(evt_priv_i, cfg_priv_mask_i) &
           (~cfg_asid_en_i | (evt_asid_i == cfg_asid_i));
    inc  = evt_id_i & cfg_line_en_i & {NUM_LINES{qual}};
    snap = (state_q == DUMP_SNAP);
  end

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    evu_line_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_line (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .inc_i       (inc[g]),
      .clear_i     (clear_i),
      .snap_i      (snap),
      .threshold_i (cfg_threshold_i),
      .snap_val_o  (snap_val[g]),
      .irq_o       (irq_o[g]),
      .ovf_o       (ovf_o[g])
    );
  end

  // dump FSM: IDLE -> SNAP (one cycle) -> DRAIN until the last beat is accepted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        DUMP_IDLE: if (dump_req_i) state_q <= DUMP_SNAP;
        DUMP_SNAP: begin
          state_q <= DUMP_DRAIN;
          idx_q   <= '0;
        end
        DUMP_DRAIN: begin
          if (dump.dump_ready_i) begin
            if (idx_q == LAST_IDX) begin
              state_q <= DUMP_IDLE;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= DUMP_IDLE;
      endcase
    end
  end

  // shadow capture; the snapshot value already includes the SNAP-cycle increment
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) shadow_q[i] <= '0;
    end else if (snap) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) shadow_q[i] <= snap_val[i];
    end
  end

  // stream outputs are registered-state driven, so they hold while ready is low
  always_comb begin
    dump_busy_o       = (state_q != DUMP_IDLE);
    dump.dump_valid_o = (state_q == DUMP_DRAIN);
    dump.dump_idx_o   = idx_q;
    dump.dump_data_o  = shadow_q[idx_q];
    dump.dump_last_o  = (state_q == DUMP_DRAIN) && (idx_q == LAST_IDX);
  end

endmodule
